// File: rtl/apb3_master_arbiter.sv
// apb3_master_arbiter: round-robin sharing of one APB3 master bus between several requesters
module apb3_master_arbiter #(
  parameter int APB_ADDR_WIDTH_P   = 32,
  parameter int APB_DATA_WIDTH_P   = 32,
  parameter int APB_NR_OF_SLAVES_P = 4,
  parameter int NR_OF_REQ_P        = 2,
  parameter int SLAVE_SEL_LSB_P    = 12,
  parameter int TIMEOUT_P          = 255
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NR_OF_REQ_P-1:0]                     req_valid,
  output logic [NR_OF_REQ_P-1:0]                     req_ready,
  input  logic [NR_OF_REQ_P-1:0]                     req_write,
  input  logic [NR_OF_REQ_P*APB_ADDR_WIDTH_P-1:0]    req_addr,
  input  logic [NR_OF_REQ_P*APB_DATA_WIDTH_P-1:0]    req_wdata,
  output logic [NR_OF_REQ_P-1:0]                     rsp_valid,
  output logic [APB_DATA_WIDTH_P-1:0]                rsp_rdata,
  output logic                                       rsp_slverr,
  output logic [APB_NR_OF_SLAVES_P-1:0]              psel,
  output logic                                       penable,
  output logic [APB_ADDR_WIDTH_P-1:0]                paddr,
  output logic                                       pwrite,
  output logic [APB_DATA_WIDTH_P-1:0]                pwdata,
  input  logic [APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P-1:0] prdata,
  input  logic [APB_NR_OF_SLAVES_P-1:0]              pready,
  input  logic [APB_NR_OF_SLAVES_P-1:0]              pslverr
);
  localparam int AW = APB_ADDR_WIDTH_P;
  localparam int DW = APB_DATA_WIDTH_P;
  localparam int NS = APB_NR_OF_SLAVES_P;
  localparam int NR = NR_OF_REQ_P;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int PW = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW = $clog2(TIMEOUT_P + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t          state_q, state_n;
  logic [PW-1:0]   ptr_q, ptr_n, g, gnt_q;
  logic            any, take, dec_ok;
  logic [AW-1:0]   addr_g;
  logic [DW-1:0]   wdata_g;
  logic            write_g;
  logic [SW-1:0]   idx_g;
  logic [CW-1:0]   cnt_q, cnt_inc;
  logic            sel_ready, sel_err, timed_out, done;
  logic [DW-1:0]   sel_rdata;
  logic [NS-1:0]   psel_n;
  logic            penable_n;
  logic [NR-1:0]   rsp_valid_n;
  logic [DW-1:0]   rsp_rdata_n;
  logic            rsp_slverr_n;
  // round-robin search from the pointer and fetch the winner's request fields
  always_comb begin
    logic [PW-1:0] j;
    any = 1'b0;
    g = '0;
    j = '0;
    for (int k = 0; k < NR; k++) begin
      j = PW'((int'(ptr_q) + k) % NR);
      if (!any && req_valid[j]) begin
        any = 1'b1;
        g = j;
      end
    end
    addr_g = '0;
    wdata_g = '0;
    write_g = 1'b0;
    for (int r = 0; r < NR; r++) begin
      if (int'(g) == r) begin
        addr_g = req_addr[r*AW +: AW];
        wdata_g = req_wdata[r*DW +: DW];
        write_g = req_write[r];
      end
    end
    idx_g = addr_g[SLAVE_SEL_LSB_P +: SW];
    dec_ok = int'(idx_g) < NS;
    ptr_n = PW'((int'(g) + 1) % NR);
    take = (state_q == IDLE) && any && !rst;
  end
  // response mux from the selected slave and transfer termination
  always_comb begin
    sel_rdata = '0;
    for (int s = 0; s < NS; s++) begin
      if (psel[s]) sel_rdata = prdata[s*DW +: DW];
    end
    sel_ready = |(pready & psel);
    sel_err = |(pslverr & psel);
    cnt_inc = cnt_q + CW'(1);
    timed_out = cnt_inc == CW'(TIMEOUT_P);
    done = sel_ready || timed_out;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_n;
  end
  // next-state logic
  always_comb begin
    state_n = (state_q == IDLE)  ? ((take && dec_ok) ? SETUP : IDLE) :
              (state_q == SETUP) ? ACCESS :
              (done ? IDLE : ACCESS);
  end
  // next values of the registered outputs plus the combinational grant pulse
  always_comb begin
    req_ready = take ? NR'(1) << g : '0;
    psel_n = (state_q == IDLE) ? ((take && dec_ok) ? NS'(1) << idx_g : '0) :
             (state_q == SETUP || !done) ? psel : '0;
    penable_n = (state_q == SETUP) || (state_q == ACCESS && !done);
    rsp_valid_n = (state_q == IDLE) ? ((take && !dec_ok) ? NR'(1) << g : '0) :
                  (state_q == ACCESS && done) ? NR'(1) << gnt_q : '0;
    rsp_rdata_n = (state_q == ACCESS && sel_ready && !pwrite) ? sel_rdata : '0;
    rsp_slverr_n = (state_q == IDLE) ? (take && !dec_ok) :
                   (state_q == ACCESS) && (sel_ready ? sel_err : timed_out);
  end
  // output, latch, pointer and timeout counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      psel <= '0;
      penable <= 1'b0;
      paddr <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_slverr <= 1'b0;
      ptr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
    end else begin
      psel <= psel_n;
      penable <= penable_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_slverr <= rsp_slverr_n;
      cnt_q <= (state_q == ACCESS) ? cnt_inc : '0;
      if (take) begin
        ptr_q <= ptr_n;
        gnt_q <= g;
      end
      if (take && dec_ok) begin
        paddr <= addr_g;
        pwrite <= write_g;
        pwdata <= wdata_g;
      end
    end
  end
endmodule

// File: tb/tb_apb3_master_arbiter.sv
// tb_apb3_master_arbiter: directed checks of arbitration, APB sequencing, decode error, timeout and reset
module tb_apb3_master_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0] req_valid, req_ready, req_write, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic rsp_slverr, penable, pwrite;
  logic [3:0] psel, pready, pslverr;
  logic [127:0] prdata;
  logic [1:0] b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
  logic [63:0] b_req_addr, b_req_wdata;
  logic [31:0] b_rsp_rdata, b_paddr, b_pwdata;
  logic b_rsp_slverr, b_penable, b_pwrite;
  logic [2:0] b_psel, b_pready, b_pslverr;
  logic [95:0] b_prdata;
  int checks = 0;
  int errors = 0;
  apb3_master_arbiter #(.APB_NR_OF_SLAVES_P(4), .TIMEOUT_P(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  apb3_master_arbiter #(.APB_NR_OF_SLAVES_P(3), .TIMEOUT_P(8)) dut_dec (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_slverr(b_rsp_slverr), .psel(b_psel), .penable(b_penable), .paddr(b_paddr), .pwrite(b_pwrite),
    .pwdata(b_pwdata), .prdata(b_prdata), .pready(b_pready), .pslverr(b_pslverr)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = '0; pslverr = '0;
    b_req_valid = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
    b_prdata = '0; b_pready = '0; b_pslverr = '0;
    repeat (3) tick();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_b_psel", b_psel, 0);
    rst = 1'b0;
    tick();
    prdata[63:32] = 32'hDEADBEEF; pready = 4'b0010;
    req_addr[31:0] = 32'h0000_1004; req_write = 2'b00; req_valid = 2'b01;
    #1;
    chk("rd_req_ready", req_ready, 2'b01);
    tick(); req_valid = '0;
    chk("rd_setup_psel", psel, 4'b0010);
    chk("rd_setup_penable", penable, 0);
    chk("rd_paddr", paddr, 32'h0000_1004);
    chk("rd_pwrite", pwrite, 0);
    tick();
    chk("rd_access_psel", psel, 4'b0010);
    chk("rd_access_penable", penable, 1);
    tick();
    chk("rd_done_psel", psel, 0);
    chk("rd_done_penable", penable, 0);
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_slverr", rsp_slverr, 0);
    tick();
    chk("rd_rsp_pulse", rsp_valid, 0);
    pready = '0; prdata[127:96] = 32'hCAFEF00D;
    req_addr[31:0] = 32'h0000_3000; req_wdata[31:0] = 32'h1234_5678; req_write = 2'b01; req_valid = 2'b01;
    #1;
    chk("wr_req_ready", req_ready, 2'b01);
    tick(); req_valid = '0;
    chk("wr_setup_psel", psel, 4'b1000);
    chk("wr_setup_penable", penable, 0);
    chk("wr_pwrite", pwrite, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wr_wait_penable", penable, 1);
      chk("wr_wait_paddr", paddr, 32'h0000_3000);
      chk("wr_wait_pwdata", pwdata, 32'h1234_5678);
      chk("wr_wait_rsp_valid", rsp_valid, 0);
    end
    tick(); pready = 4'b1000; pslverr = 4'b1000;
    chk("wr_last_penable", penable, 1);
    chk("wr_last_psel", psel, 4'b1000);
    tick();
    chk("wr_rsp_valid", rsp_valid, 2'b01);
    chk("wr_rsp_slverr", rsp_slverr, 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_done_psel", psel, 0);
    pready = '0; pslverr = '0; req_write = '0;
    prdata[95:64] = 32'h55AA_55AA; req_addr[63:32] = 32'h0000_2000; req_valid = 2'b10;
    #1;
    chk("to_req_ready", req_ready, 2'b10);
    tick(); req_valid = '0;
    chk("to_setup_psel", psel, 4'b0100);
    chk("to_setup_penable", penable, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_access_penable", penable, 1);
      chk("to_access_psel", psel, 4'b0100);
      chk("to_access_rsp_valid", rsp_valid, 0);
    end
    tick();
    chk("to_done_psel", psel, 0);
    chk("to_done_penable", penable, 0);
    chk("to_rsp_valid", rsp_valid, 2'b10);
    chk("to_rsp_slverr", rsp_slverr, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    pready = 4'b1111; prdata[31:0] = 32'h0000_00A0; prdata[63:32] = 32'h0000_00B1;
    req_addr = {32'h0000_1020, 32'h0000_0010}; req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        chk("rr_rsp_valid", rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
        chk("rr_rsp_rdata", rsp_rdata, (k % 2 == 1) ? 32'hA0 : 32'hB1);
      end
      tick();
      chk("rr_psel", psel, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      tick();
      tick();
    end
    chk("rr_last_rsp_valid", rsp_valid, 2'b10);
    chk("rr_last_rsp_rdata", rsp_rdata, 32'hB1);
    req_valid = '0;
    #1;
    chk("rr_idle_ready", req_ready, 0);
    tick();
    pready = '0; req_addr[31:0] = 32'h0000_1000; req_valid = 2'b01;
    #1;
    chk("ra_req_ready", req_ready, 2'b01);
    tick(); req_valid = '0;
    tick();
    chk("ra_access_penable", penable, 1);
    rst = 1'b1;
    tick();
    chk("ra_psel", psel, 0);
    chk("ra_penable", penable, 0);
    chk("ra_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    tick();
    chk("ra_no_rsp", rsp_valid, 0);
    pready = 4'b1111; req_valid = 2'b11;
    #1;
    chk("ra_ptr_reset_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b10;
    tick();
    tick();
    chk("ra_rsp_valid_after", rsp_valid, 2'b01);
    chk("ra_rsp_rdata_after", rsp_rdata, 32'hB1);
    chk("ra_next_grant", req_ready, 2'b10);
    tick(); req_valid = '0;
    tick();
    tick();
    chk("ra_rsp_valid_req1", rsp_valid, 2'b10);
    b_req_addr[31:0] = 32'h0000_3000; b_req_valid = 2'b01;
    #1;
    chk("dec_req_ready", b_req_ready, 2'b01);
    tick(); b_req_valid = '0;
    chk("dec_psel", b_psel, 0);
    chk("dec_penable", b_penable, 0);
    chk("dec_rsp_valid", b_rsp_valid, 2'b01);
    chk("dec_rsp_slverr", b_rsp_slverr, 1);
    chk("dec_rsp_rdata", b_rsp_rdata, 0);
    tick();
    chk("dec_rsp_pulse", b_rsp_valid, 0);
    chk("dec_psel_after", b_psel, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb3_master_arbiter.md
Name: apb3_master_arbiter

Overview:
- Shares one APB3 master bus between NR_OF_REQ_P internal requesters. Arbitration is round-robin.
- Sequences the APB3 SETUP and ACCESS phases and decodes PSEL across APB_NR_OF_SLAVES_P slaves.
- Muxes PRDATA, PREADY and PSLVERR back from the selected slave.
- Sits between register-access clients (e.g. CPU bridge, DMA config port) and the APB3 peripheral fabric.

Parameters:
- APB_ADDR_WIDTH_P, 32: address width.
- APB_DATA_WIDTH_P, 32: data width.
- APB_NR_OF_SLAVES_P, 4: number of PSEL lines, >=1.
- NR_OF_REQ_P, 2: number of requesters, >=1.
- SLAVE_SEL_LSB_P, 12: LSB of the slave index field. Index = addr[SLAVE_SEL_LSB_P +: max(1,$clog2(APB_NR_OF_SLAVES_P))].
- TIMEOUT_P, 255: maximum ACCESS cycles before forced termination, >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- req_valid  in  NR_OF_REQ_P  request pending, one bit per requester.
- req_ready  out  NR_OF_REQ_P  one-cycle grant/accept pulse.
- req_write  in  NR_OF_REQ_P  1 = write (APB_OP_WRITE_E), 0 = read.
- req_addr  in  NR_OF_REQ_P*APB_ADDR_WIDTH_P  flattened; requester i at [i*AW +: AW].
- req_wdata  in  NR_OF_REQ_P*APB_DATA_WIDTH_P  flattened write data.
- rsp_valid  out  NR_OF_REQ_P  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  APB_DATA_WIDTH_P  read data, valid with rsp_valid.
- rsp_slverr  out  1  error flag, valid with rsp_valid.
- psel  out  APB_NR_OF_SLAVES_P  one-hot slave select.
- penable  out  1  APB enable.
- paddr  out  APB_ADDR_WIDTH_P  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  APB_DATA_WIDTH_P  APB write data.
- prdata  in  APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P  per-slave read data, flattened.
- pready  in  APB_NR_OF_SLAVES_P  per-slave ready.
- pslverr  in  APB_NR_OF_SLAVES_P  per-slave error.

Behaviour:
- Single clock clk. Reset rst is synchronous and active high.
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer = 0; timeout counter = 0.
- All outputs are registered except req_ready.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from the pointer upward, with wrap.
  - req_ready[g] = 1 combinationally in that cycle.
  - Latch addr, wdata and write of requester g; compute the slave index.
  - Pointer <= (g+1) mod NR_OF_REQ_P.
  - If index < APB_NR_OF_SLAVES_P, go to SETUP. Otherwise it is a decode error: no APB transfer, rsp_valid[g]=1 and rsp_slverr=1 next cycle, rsp_rdata=0, stay in IDLE.
- SETUP: psel[idx]=1, penable=0, paddr/pwrite/pwdata driven from the latches. Next state is always ACCESS.
- ACCESS: psel[idx]=1, penable=1; paddr/pwdata/pwrite stable; timeout counter increments each cycle.
  - pready[idx]=1: capture prdata[idx] (reads only; writes return 0) and pslverr[idx]. Next cycle: psel=0, penable=0, rsp_valid[g]=1, state IDLE.
  - Counter reaches TIMEOUT_P with no pready: same exit, with rsp_slverr=1 and rsp_rdata=0.
- Counter clears on entry to SETUP.
- Unselected slaves' prdata/pready/pslverr are ignored.
- Timing:
  - Minimum transfer: grant at cycle 0, SETUP cycle 1, ACCESS cycle 2 with pready, rsp_valid cycle 3.
  - The IDLE cycle that shows rsp_valid may grant the next request, giving a back-to-back period of 3 cycles.
- rsp_valid has no backpressure: a requester must accept it.
- A requester holds req_valid and its fields stable until req_ready, and must not re-request before its rsp_valid. The arbiter does not check this.
- Simultaneous requests: exactly one req_ready bit per grant; the others wait. A requester is not starved: worst-case wait is (NR_OF_REQ_P-1) transfers.
- req_valid deasserting before grant: the request is dropped silently, which is legal.
- Reset mid-transfer: psel and penable are 0 the next cycle; no rsp_valid is issued for the aborted transfer.
- psel is never multi-hot. penable=1 only when psel is non-zero.

Test Plan:
- Single read: req 0, addr 0x0000_1004 (slave 1), slave 1 returns 0xDEADBEEF with pready in the first ACCESS cycle -> psel=4'b0010 in cycles 1-2, penable only in cycle 2, rsp_valid[0] in cycle 3, rsp_rdata=0xDEADBEEF, rsp_slverr=0.
- Wait states plus error: write to 0x0000_3000, slave 3 holds pready=0 for 5 cycles, then pready=1 with pslverr=1 -> paddr and pwdata stable throughout, rsp_slverr=1, rsp_rdata=0.
- Round-robin: req 0 and req 1 both valid continuously for 4 transfers -> grant order 0,1,0,1; each grant occurs in the same cycle as the previous rsp_valid (3-cycle period).
- Decode error: NR_OF_SLAVES=3, addr 0x0000_3000 -> no psel asserted, rsp_valid one cycle after req_ready, rsp_slverr=1.
- Timeout: TIMEOUT_P=8, slave never asserts pready -> ACCESS lasts exactly 8 cycles, then psel drops and rsp_slverr=1.
- Reset mid-ACCESS: assert rst for 1 cycle during ACCESS -> all outputs 0 the next cycle, no rsp_valid, and the next request is arbitrated from requester 0.
